bmm150_seq_ctrl: RTL



---
 rtl/bmm150_pkg.sv | 33 +++
 rtl/bmm150_spi_txn.sv | 63 ++++++
 rtl/bmm150_seq_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/bmm150_pkg.sv
// Shared types and register map for the BMM150 command sequencer.
package bmm150_pkg;

  typedef enum logic [2:0] {
    ST_PWR_ON,
    ST_PWR_WAIT,
    ST_ID_READ,
    ST_SET_MODE,
    ST_WAIT,
    ST_READ,
    ST_PUBLISH,
    ST_ERROR
  } state_t;

  typedef enum logic {
    TXN_IDLE,
    TXN_BUSY
  } txn_state_t;

  localparam logic [7:0] REG_CHIP_ID    = 8'h40;
  localparam logic [7:0] REG_DATA_X_LSB = 8'h42;
  localparam logic [7:0] REG_PWR        = 8'h4B;
  localparam logic [7:0] REG_OPMODE     = 8'h4C;
  localparam logic [7:0] CHIP_ID_VAL    = 8'h32;
  localparam logic [7:0] READ_FLAG      = 8'h80;
  localparam logic [7:0] PWR_ON_VAL     = 8'h01;
  localparam logic [7:0] OPMODE_NORMAL  = 8'h00;

  function automatic logic [7:0] rd_addr(input logic [7:0] reg_a);
    return READ_FLAG | reg_a;
  endfunction

endpackage

// File: rtl/bmm150_spi_txn.sv
// Single SPI master transaction: start pulse, hold command, wait for done or timeout.
module bmm150_spi_txn
  import bmm150_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] wdata_i,
  input  logic       rw_i,
  output logic       ack_o,
  output logic       timeout_o,
  output logic       spi_start_o,
  output logic [7:0] spi_reg_addr_o,
  output logic [7:0] spi_tx_data_o,
  output logic       spi_rw_o,
  input  logic       spi_busy_i,
  input  logic       spi_done_i
);

  // req_i is a level held by the FSM; a transaction is launched only from idle
  // with the master not busy, and ends with exactly one ack_o or timeout_o cycle,
  // during which the FSM consumes the result and changes its request.
  txn_state_t  state_q;
  logic [31:0] tmo_q;

  assign ack_o     = (state_q == TXN_BUSY) && spi_done_i;
  assign timeout_o = (state_q == TXN_BUSY) && !spi_done_i &&
                     (tmo_q == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= TXN_IDLE;
      tmo_q          <= '0;
      spi_start_o    <= 1'b0;
      spi_reg_addr_o <= '0;
      spi_tx_data_o  <= '0;
      spi_rw_o       <= 1'b0;
    end else begin
      spi_start_o <= 1'b0;
      case (state_q)
        TXN_IDLE: begin
          if (req_i && !spi_busy_i) begin
            spi_start_o    <= 1'b1;
            spi_reg_addr_o <= addr_i;
            spi_tx_data_o  <= wdata_i;
            spi_rw_o       <= rw_i;
            tmo_q          <= '0;
            state_q        <= TXN_BUSY;
          end
        end
        TXN_BUSY: begin
          if (ack_o || timeout_o) state_q <= TXN_IDLE;
          else                    tmo_q   <= tmo_q + 32'd1;
        end
        default: state_q <= TXN_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/bmm150_seq_ctrl.sv
// BMM150 bring-up and periodic data-register sampler driving an SPI master.
module bmm150_seq_ctrl
  import bmm150_pkg::*;
#(
  parameter int PWRUP_CYCLES   = 150000,
  parameter int SAMPLE_CYCLES  = 500000,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int ID_RETRIES     = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  output logic               spi_start,
  output logic [7:0]         spi_reg_addr,
  output logic [7:0]         spi_tx_data,
  output logic               spi_rw,
  input  logic [7:0]         spi_rx_data,
  input  logic               spi_busy,
  input  logic               spi_done,
  output logic signed [12:0] mag_x,
  output logic signed [12:0] mag_y,
  output logic signed [14:0] mag_z,
  output logic [13:0]        rhall,
  output logic               data_valid,
  output logic               init_done,
  output logic               error
);

  state_t      state_q;
  logic [31:0] wait_q;
  logic [31:0] period_q;
  logic [7:0]  retry_q;
  logic [2:0]  idx_q;
  logic        pending_q;
  logic [7:0]  buf_q [8];

  logic        txn_req, txn_rw, txn_ack, txn_tmo;
  logic [7:0]  txn_addr, txn_wdata;
  logic        period_active, period_tick;

  always_comb begin
    txn_req   = 1'b0;
    txn_rw    = 1'b0;
    txn_addr  = '0;
    txn_wdata = '0;
    case (state_q)
      ST_PWR_ON:   begin txn_req = 1'b1; txn_addr = REG_PWR; txn_wdata = PWR_ON_VAL; end
      ST_ID_READ:  begin txn_req = 1'b1; txn_rw = 1'b1; txn_addr = rd_addr(REG_CHIP_ID); end
      ST_SET_MODE: begin txn_req = 1'b1; txn_addr = REG_OPMODE; txn_wdata = OPMODE_NORMAL; end
      ST_READ:     begin
        txn_req  = 1'b1;
        txn_rw   = 1'b1;
        txn_addr = rd_addr(REG_DATA_X_LSB + {5'd0, idx_q});
      end
      default: ;
    endcase
  end

  bmm150_spi_txn #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_txn (
    .clk            (clk),
    .rst            (rst),
    .req_i          (txn_req),
    .addr_i         (txn_addr),
    .wdata_i        (txn_wdata),
    .rw_i           (txn_rw),
    .ack_o          (txn_ack),
    .timeout_o      (txn_tmo),
    .spi_start_o    (spi_start),
    .spi_reg_addr_o (spi_reg_addr),
    .spi_tx_data_o  (spi_tx_data),
    .spi_rw_o       (spi_rw),
    .spi_busy_i     (spi_busy),
    .spi_done_i     (spi_done)
  );

  // The sample period keeps running through a burst so an overrun is remembered.
  assign period_active = enable && (state_q inside {ST_WAIT, ST_READ, ST_PUBLISH});
  assign period_tick   = period_active && (period_q == 32'(SAMPLE_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_PWR_ON;
      wait_q     <= '0;
      period_q   <= '0;
      retry_q    <= '0;
      idx_q      <= '0;
      pending_q  <= 1'b0;
      for (int i = 0; i < 8; i++) buf_q[i] <= '0;
      mag_x      <= '0;
      mag_y      <= '0;
      mag_z      <= '0;
      rhall      <= '0;
      data_valid <= 1'b0;
      init_done  <= 1'b0;
      error      <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (period_tick)        period_q <= '0;
      else if (period_active) period_q <= period_q + 32'd1;
      else                    period_q <= '0;

      if (txn_tmo) begin
        state_q <= ST_ERROR;
        error   <= 1'b1;
      end else begin
        case (state_q)
          ST_PWR_ON: if (txn_ack) begin
            wait_q  <= '0;
            state_q <= ST_PWR_WAIT;
          end
          ST_PWR_WAIT: begin
            if (wait_q == 32'(PWRUP_CYCLES - 1)) begin
              wait_q  <= '0;
              state_q <= ST_ID_READ;
            end else begin
              wait_q <= wait_q + 32'd1;
            end
          end
          ST_ID_READ: if (txn_ack) begin
            if (spi_rx_data == CHIP_ID_VAL) begin
              state_q <= ST_SET_MODE;
            end else begin
              retry_q <= retry_q + 8'd1;
              wait_q  <= '0;
              if (retry_q == 8'(ID_RETRIES - 1)) begin
                state_q <= ST_ERROR;
                error   <= 1'b1;
              end else begin
                state_q <= ST_PWR_WAIT;
              end
            end
          end
          ST_SET_MODE: if (txn_ack) begin
            init_done <= 1'b1;
            state_q   <= ST_WAIT;
          end
          ST_WAIT: begin
            pending_q <= 1'b0;
            if (period_tick) begin
              idx_q   <= '0;
              state_q <= ST_READ;
            end
          end
          ST_READ: begin
            if (period_tick) pending_q <= 1'b1;
            else if (!enable) pending_q <= 1'b0;
            if (txn_ack) begin
              buf_q[idx_q] <= spi_rx_data;
              idx_q        <= idx_q + 3'd1;
              if (idx_q == 3'd7) state_q <= ST_PUBLISH;
            end
          end
          ST_PUBLISH: begin
            // Bit 0 of the RHALL LSB is the sensor's data-ready flag.
            if (buf_q[6][0]) begin
              mag_x      <= {buf_q[1], buf_q[0][7:3]};
              mag_y      <= {buf_q[3], buf_q[2][7:3]};
              mag_z      <= {buf_q[5], buf_q[4][7:1]};
              rhall      <= {buf_q[7], buf_q[6][7:2]};
              data_valid <= 1'b1;
            end
            pending_q <= 1'b0;
            idx_q     <= '0;
            if (enable && (pending_q || period_tick)) state_q <= ST_READ;
            else                                      state_q <= ST_WAIT;
          end
          ST_ERROR: error <= 1'b1;
          default:  state_q <= ST_ERROR;
        endcase
      end
    end
  end

endmodule
